// File: rtl/fifo_drain_uart_tx_if.sv
// FIFO read-side bundle between the UART drain engine (master) and the upstream FIFO (slave).
interface fifo_drain_uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_data;

  modport master (input fifo_empty, input fifo_data, output fifo_rd_en);
  modport slave  (output fifo_empty, output fifo_data, input fifo_rd_en);
endinterface

// File: rtl/fifo_drain_uart_tx.sv
// Pulls one word at a time from a FIFO and shifts it out as an 8N1-style UART frame.
// state | meaning
// IDLE  | line high, waiting for enable and a non-empty FIFO
// FETCH | one-cycle read strobe to the FIFO
// LOAD  | FIFO data valid, captured into the shift register
// START | start bit (tx low) for CLKS_PER_BIT cycles
// DATA  | DATA_WIDTH bits, LSB first
// STOP  | stop bit (tx high); frame_done on its last cycle
module fifo_drain_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                         clk,
  input  logic                         rstN,
  input  logic                         enable,
  fifo_drain_uart_tx_if.master         fifo,
  output logic                         tx,
  output logic                         busy,
  output logic                         frame_done,
  output logic [15:0]                  frame_count
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      bit_cnt;
  logic [IDX_W-1:0]      bit_idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  armed;
  logic                  bit_end;
  logic                  last_idx;

  assign bit_end  = (bit_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign last_idx = (bit_idx == IDX_W'(DATA_WIDTH - 1));

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    tx         = 1'b1;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (armed && enable && !fifo.fifo_empty) state_nxt = FETCH;
      end
      FETCH: state_nxt = LOAD;
      LOAD:  state_nxt = START;
      START: begin
        tx = 1'b0;
        if (bit_end) state_nxt = DATA;
      end
      DATA: begin
        tx = shreg[0];
        if (bit_end && last_idx) state_nxt = STOP;
      end
      STOP: begin
        if (bit_end) begin
          frame_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // armed holds off the first fetch until one edge after reset release
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      armed           <= 1'b0;
      fifo.fifo_rd_en <= 1'b0;
      bit_cnt         <= '0;
      bit_idx         <= '0;
      shreg           <= '0;
    end else begin
      armed           <= 1'b1;
      fifo.fifo_rd_en <= (state_nxt == FETCH);

      if (state == START || state == DATA || state == STOP)
        bit_cnt <= bit_end ? '0 : bit_cnt + 1'b1;
      else
        bit_cnt <= '0;

      if (state == DATA) begin
        if (bit_end) bit_idx <= last_idx ? '0 : bit_idx + 1'b1;
      end else begin
        bit_idx <= '0;
      end

      if (state == LOAD)
        shreg <= fifo.fifo_data;
      else if (state == DATA && bit_end)
        shreg <= shreg >> 1;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)           frame_count <= '0;
    else if (frame_done) frame_count <= frame_count + 16'd1;
  end

endmodule

// File: tb/tb_fifo_drain_uart_tx.sv
// Directed/randomized bench: FIFO model plus a frame-level reference of the expected serial waveform.
module tb_fifo_drain_uart_tx;
  localparam int DW  = 8;
  localparam int CPB = 4;
  localparam int FRAME_CYC = 10 * CPB;

  logic        clk = 1'b0;
  logic        rstN;
  logic        enable;
  logic        tx, busy, frame_done;
  logic [15:0] frame_count;

  fifo_drain_uart_tx_if #(.DATA_WIDTH(DW)) ifc ();

  fifo_drain_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rstN        (rstN),
    .enable      (enable),
    .fifo        (ifc.master),
    .tx          (tx),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] q[$];
  int cyc = 0;
  int rd_pulses = 0;
  int done_pulses = 0;
  int total = 0;
  int passed = 0;
  int failed = 0;
  logic [15:0] exp_count = '0;

  // FIFO model: data appears the cycle after the strobe is sampled, garbage otherwise
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ifc.fifo_rd_en) rd_pulses <= rd_pulses + 1;
    if (frame_done) done_pulses <= done_pulses + 1;
    if (ifc.fifo_rd_en && q.size() > 0) ifc.fifo_data <= q.pop_front();
    else ifc.fifo_data <= DW'($urandom);
    ifc.fifo_empty <= (q.size() == 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_fetch(input int budget, output int waited);
    waited = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (ifc.fifo_rd_en === 1'b1) begin
        waited = i;
        break;
      end
    end
    chk("fetch_seen", ifc.fifo_rd_en, 1);
  endtask

  // Entered at the negedge where the read strobe is visible; leaves at the IDLE cycle after STOP.
  task automatic check_frame(input logic [DW-1:0] b, input int drop_at);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    chk("fetch_busy", busy, 1);
    chk("fetch_tx", tx, 1);
    @(negedge clk);
    chk("load_rd_en", ifc.fifo_rd_en, 0);
    chk("load_tx", tx, 1);
    for (int k = 0; k < FRAME_CYC; k++) begin
      @(negedge clk);
      if (k == drop_at) enable = 1'b0;
      chk("frame_tx", tx, fr[k / CPB]);
      chk("frame_done", frame_done, (k == FRAME_CYC - 1));
      chk("frame_busy", busy, 1);
    end
    exp_count = exp_count + 16'd1;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("frame_count", frame_count, exp_count);
  endtask

  initial begin
    int w, f1, r0, d0;
    logic [DW-1:0] b, b2;

    enable = 1'b1;
    rstN   = 1'b0;
    q.push_back(8'hA5);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", ifc.fifo_rd_en, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_count", frame_count, 0);

    // Single frame 0xA5, first fetch on the second edge after reset release
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    chk("rel_first_edge_no_fetch", ifc.fifo_rd_en, 0);
    @(negedge clk);
    chk("rel_second_edge_fetch", ifc.fifo_rd_en, 1);
    check_frame(8'hA5, -1);
    chk("single_rd_pulses", rd_pulses, 1);
    chk("single_done_pulses", done_pulses, 1);

    // Back-to-back 0x00 then 0xFF
    q.push_back(8'h00);
    q.push_back(8'hFF);
    wait_fetch(10, w);
    chk("start_latency", w, 2);
    f1 = cyc;
    check_frame(8'h00, -1);
    @(negedge clk);
    chk("b2b_fetch", ifc.fifo_rd_en, 1);
    chk("b2b_spacing", cyc - f1, 43);
    check_frame(8'hFF, -1);

    // Empty FIFO: idle line, no fetch
    r0 = rd_pulses;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("empty_tx", tx, 1);
      chk("empty_busy", busy, 0);
    end
    chk("empty_no_fetch", rd_pulses, r0);

    // Enable dropped mid-DATA: frame completes, next word waits
    b  = DW'($urandom);
    b2 = DW'($urandom);
    q.push_back(b);
    q.push_back(b2);
    wait_fetch(10, w);
    r0 = rd_pulses + 1;
    check_frame(b, 3 * CPB + 1);
    repeat (60) @(negedge clk);
    chk("disabled_no_fetch", rd_pulses, r0);
    chk("disabled_busy", busy, 0);
    enable = 1'b1;
    wait_fetch(10, w);
    check_frame(b2, -1);

    // Random words with random idle gaps
    for (int n = 0; n < 6; n++) begin
      b = DW'($urandom);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      q.push_back(b);
      wait_fetch(20, w);
      check_frame(b, -1);
    end

    // Reset during data bit 3
    b = DW'($urandom);
    q.push_back(b);
    wait_fetch(10, w);
    @(negedge clk);
    repeat (4 * CPB + 2) @(negedge clk);
    chk("pre_rst_bit3", tx, b[3]);
    #2;
    rstN   = 1'b0;
    enable = 1'b0;
    #1;
    chk("midrst_tx", tx, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_rd_en", ifc.fifo_rd_en, 0);
    chk("midrst_count", frame_count, 0);
    exp_count = '0;
    @(negedge clk);
    rstN = 1'b1;
    b = DW'($urandom);
    q.push_back(b);
    r0 = rd_pulses;
    repeat (20) @(negedge clk);
    chk("postrst_no_fetch", rd_pulses, r0);
    chk("postrst_count", frame_count, 0);
    enable = 1'b1;
    wait_fetch(10, w);
    check_frame(b, -1);

    // Counter wrap
    force dut.frame_count = 16'hFFFF;
    @(negedge clk);
    release dut.frame_count;
    exp_count = 16'hFFFF;
    @(negedge clk);
    chk("preload_count", frame_count, 16'hFFFF);
    d0 = done_pulses;
    b = DW'($urandom);
    q.push_back(b);
    wait_fetch(10, w);
    check_frame(b, -1);
    chk("wrap_count", frame_count, 16'h0000);
    chk("wrap_done_once", done_pulses, d0 + 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fifo_drain_uart_tx.md
FIFO_DRAIN_UART_TX -- requirements
Module: fifo_drain_uart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of a FIFO word and of a serial data field.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, legal range 2 or more: clk cycles per serial bit.
REQ-003 SHALL have input clk, 1 bit: clock; all state changes on its rising edge.
REQ-004 SHALL have input rstN, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have input enable, 1 bit: permits starting a new frame.
REQ-006 SHALL have input fifo_empty, 1 bit: upstream FIFO empty flag.
REQ-007 SHALL have output fifo_rd_en, 1 bit: registered read strobe to the FIFO.
REQ-008 SHALL have input fifo_data, DATA_WIDTH bits: FIFO read data, valid the cycle after fifo_rd_en is sampled.
REQ-009 SHALL have output tx, 1 bit: serial line, idle high.
REQ-010 SHALL have output busy, 1 bit: high in every state except IDLE.
REQ-011 SHALL have output frame_done, 1 bit: one-cycle pulse at frame end.
REQ-012 SHALL have output frame_count, 16 bits: number of completed frames.

Function
REQ-013 SHALL implement the FSM states IDLE, FETCH, LOAD, START, DATA and STOP.
REQ-014 In IDLE, when enable=1 and fifo_empty=0, SHALL go to FETCH on the next cycle; otherwise SHALL stay in IDLE.
REQ-015 In FETCH, SHALL drive fifo_rd_en=1 for exactly one cycle, then go to LOAD.
REQ-016 fifo_rd_en SHALL be 0 in every state except FETCH.
REQ-017 In LOAD, SHALL capture fifo_data into a DATA_WIDTH shift register and go to START.
REQ-018 In START, SHALL drive tx=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-019 In DATA, SHALL send DATA_WIDTH bits, LSB first, each held CLKS_PER_BIT cycles, then go to STOP.
REQ-020 The DATA bit index SHALL count from 0 to DATA_WIDTH-1 and leave DATA when it reaches DATA_WIDTH-1.
REQ-021 In STOP, SHALL drive tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
REQ-022 SHALL assert frame_done during the last STOP cycle only.
REQ-023 frame_count SHALL increment by 1 at the end of each STOP and wrap from 0xFFFF to 0x0000.
REQ-024 A bit-timing counter SHALL run from 0 to CLKS_PER_BIT-1, reload to 0 at each bit boundary, and be sized $clog2(CLKS_PER_BIT).
REQ-025 Latency: if IDLE sees the start condition in cycle t, fifo_rd_en SHALL be high in t+1 and tx SHALL first go low in t+3.
REQ-026 Back-to-back frames SHALL have a minimum FETCH-to-FETCH spacing of 10*CLKS_PER_BIT+3 cycles, because the FSM always passes through IDLE for one cycle.
REQ-027 Deasserting enable mid-frame SHALL NOT abort the frame; it SHALL only block the next fetch.
REQ-028 fifo_empty SHALL be ignored outside IDLE, and fifo_rd_en SHALL never assert when IDLE sampled fifo_empty=1.
REQ-029 fifo_data SHALL be sampled only in LOAD; changes on it at any other time SHALL NOT affect tx.

Reset
REQ-030 While rstN=0, SHALL force state to IDLE, tx=1, fifo_rd_en=0, busy=0, frame_done=0, frame_count=0, and clear the shift register and both counters.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately (tx=1 asynchronously) and SHALL NOT increment frame_count.
REQ-032 After rstN deasserts, the first fetch SHALL occur no earlier than the second rising clk edge.

Verification (CLKS_PER_BIT=4, DATA_WIDTH=8)
REQ-033 Single frame: FIFO holds 0xA5, enable=1. Required response:
- exactly one fifo_rd_en pulse;
- tx = 0,1,0,1,0,0,1,0,1,1, each bit for 4 cycles;
- frame_done pulses once and frame_count becomes 1.
REQ-034 Back-to-back: FIFO holds 0x00 then 0xFF. Required response: fifo_rd_en pulses 43 cycles apart; second frame data bits all 1; frame_count=2.
REQ-035 Empty and enable gating. Required response:
- fifo_empty=1 for 100 cycles: tx=1, busy=0, no fifo_rd_en;
- enable dropped during DATA: current frame completes, no further fetch.
REQ-036 Reset during bit 3 of the data field: tx=1 and busy=0 immediately, frame_count stays 0, no fifo_rd_en until re-enabled.
REQ-037 Counter wrap: preload frame_count to 0xFFFF (force or 65535 frames), send one frame. Required response: frame_count=0x0000 and frame_done pulses once.
